// File: rtl/png_stream_serializer.sv
// Word FIFO feeding a shift register that streams PNG file bytes MSB-first,
// OUT_BYTES per beat, over a valid/ready handshake with frame markers and tags.
module png_stream_serializer #(
    parameter int unsigned IN_BYTES  = 69,
    parameter int unsigned OUT_BYTES = 1,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned LEN_W     = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    output logic                         load_ready,
    input  logic [IN_BYTES*8-1:0]        data_in,
    input  logic [LEN_W-1:0]             load_len,
    input  logic                         load_sof,
    input  logic                         load_eof,
    input  logic [31:0]                  ip,
    input  logic [15:0]                  port,
    output logic [OUT_BYTES*8-1:0]       data_out,
    output logic [OUT_BYTES-1:0]         okeep,
    output logic                         ovalid,
    input  logic                         oready,
    output logic                         ostart,
    output logic                         olast,
    output logic [31:0]                  otag_ip,
    output logic [15:0]                  otag_port,
    output logic [31:0]                  byte_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         load_err
);

    localparam int unsigned IW    = IN_BYTES * 8;
    localparam int unsigned OW    = OUT_BYTES * 8;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state, state_next;
    logic [IW-1:0]      mem_data [DEPTH];
    logic [LEN_W-1:0]   mem_len  [DEPTH];
    logic               mem_sof  [DEPTH];
    logic               mem_eof  [DEPTH];
    logic [31:0]        mem_ip   [DEPTH];
    logic [15:0]        mem_port [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level_next;

    logic [IW-1:0]      sreg;
    logic [LEN_W-1:0]   rem;
    logic               cur_sof, cur_eof, first_beat;
    logic               len_ok, push, pop, beat_done, word_end, level_nz;
    logic [31:0]        keep_cnt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        len_ok     = (load_len != '0) && (load_len <= LEN_W'(IN_BYTES));
        push       = load && load_ready && len_ok;
        beat_done  = (state == SHIFT) && oready;
        word_end   = beat_done && (rem <= LEN_W'(OUT_BYTES));
        level_nz   = (level != '0);
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (level_nz) begin
                    pop        = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // Reload on the final beat keeps beats continuous across words
                if (word_end) begin
                    if (level_nz) pop = 1'b1;
                    else          state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        level_next = level + LVL_W'(push) - LVL_W'(pop);
    end

    always_comb begin
        ovalid   = (state == SHIFT);
        data_out = sreg[IW-1 -: OW];
        okeep    = '0;
        for (int unsigned i = 0; i < OUT_BYTES; i++)
            okeep[OUT_BYTES-1-i] = (i < 32'(rem));
        keep_cnt = (rem > LEN_W'(OUT_BYTES)) ? OUT_BYTES : 32'(rem);
        ostart   = ovalid && cur_sof && first_beat;
        olast    = ovalid && cur_eof && (rem <= LEN_W'(OUT_BYTES));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= data_in;
            mem_len[wr_ptr]  <= load_len;
            mem_sof[wr_ptr]  <= load_sof;
            mem_eof[wr_ptr]  <= load_eof;
            mem_ip[wr_ptr]   <= ip;
            mem_port[wr_ptr] <= port;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            load_ready <= 1'b0;
            load_err   <= 1'b0;
            sreg       <= '0;
            rem        <= '0;
            cur_sof    <= 1'b0;
            cur_eof    <= 1'b0;
            first_beat <= 1'b0;
            otag_ip    <= '0;
            otag_port  <= '0;
            byte_cnt   <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            level      <= level_next;
            load_ready <= (level_next < LVL_W'(DEPTH));
            if (load && !(load_ready && len_ok)) load_err <= 1'b1;

            if (beat_done)
                byte_cnt <= ostart ? keep_cnt : byte_cnt + keep_cnt;

            if (pop) begin
                sreg       <= mem_data[rd_ptr];
                rem        <= mem_len[rd_ptr];
                cur_sof    <= mem_sof[rd_ptr];
                cur_eof    <= mem_eof[rd_ptr];
                otag_ip    <= mem_ip[rd_ptr];
                otag_port  <= mem_port[rd_ptr];
                first_beat <= 1'b1;
            end else if (beat_done) begin
                sreg       <= sreg << OW;
                rem        <= (rem > LEN_W'(OUT_BYTES)) ? rem - LEN_W'(OUT_BYTES) : '0;
                first_beat <= 1'b0;
            end
        end
    end

endmodule
